// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Defines the arbiter state encoding and the requester index type.
package mem_arb_pkg;

    localparam int N_REQ = 2;

    typedef logic req_id_t;

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t IDLE = 1'b0;
    localparam arb_state_t WAIT = 1'b1;

endpackage

// File: rtl/arb_route_fifo.sv
// Synchronous FIFO of small tags with push/pop/full/empty flags.
// A push is accepted while full if a pop happens in the same cycle.
module arb_route_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: defaults first so every path assigns every _d signal and no latch is inferred.
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) count_d = count_q + CNT_W'(1);
        if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; entries are only read once count_q says they were written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid memory port between two requesters.
// Optional MEM_PORT_ARB_PERF_EN adds a saturating conflict_cnt_o counter.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic [1:0]                m_req_i,
    output logic [1:0]                m_gnt_o,
    output logic [1:0]                m_rvalid_o,
    input  logic [1:0]                m_we_i,
    input  logic [2*ADDR_WIDTH-1:0]   m_addr_i,
    input  logic [2*DATA_WIDTH/8-1:0] m_be_i,
    input  logic [2*DATA_WIDTH-1:0]   m_wdata_i,
    output logic [2*DATA_WIDTH-1:0]   m_rdata_o,
    output logic                      s_req_o,
    input  logic                      s_gnt_i,
    input  logic                      s_rvalid_i,
    output logic                      s_we_o,
    output logic [ADDR_WIDTH-1:0]     s_addr_o,
    output logic [DATA_WIDTH/8-1:0]   s_be_o,
    output logic [DATA_WIDTH-1:0]     s_wdata_o,
    input  logic [DATA_WIDTH-1:0]     s_rdata_i,
    output logic                      err_o
`ifdef MEM_PORT_ARB_PERF_EN
   ,output logic [31:0]               conflict_cnt_o
`endif
);

    localparam int BE_W = DATA_WIDTH / 8;

    arb_state_t state_q, state_d;
    req_id_t    rr_ptr_q, rr_ptr_d;
    req_id_t    lock_id_q, lock_id_d;
    logic       err_q, err_d;

    req_id_t    winner, sel, fifo_head;
    logic       both_req, fifo_full, fifo_empty, fifo_block, handshake, rsp_pop;

    assign both_req = m_req_i[0] && m_req_i[1];
    assign winner   = both_req ? rr_ptr_q : m_req_i[1];
    // A stalled request keeps the port until granted so its fields stay stable.
    assign sel      = (state_q == WAIT) ? lock_id_q : winner;

    assign fifo_block = fifo_full && !s_rvalid_i;
    assign s_req_o    = m_req_i[sel] && !fifo_block;
    assign handshake  = s_req_o && s_gnt_i;
    assign rsp_pop    = s_rvalid_i && !fifo_empty;

    assign s_we_o    = m_we_i[sel];
    assign s_addr_o  = sel ? m_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_addr_i[ADDR_WIDTH-1:0];
    assign s_be_o    = sel ? m_be_i[2*BE_W-1:BE_W]               : m_be_i[BE_W-1:0];
    assign s_wdata_o = sel ? m_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : m_wdata_i[DATA_WIDTH-1:0];
    assign m_rdata_o = {2{s_rdata_i}};
    assign err_o     = err_q;

    always_comb begin
        m_gnt_o            = '0;
        m_gnt_o[sel]       = handshake;
        m_rvalid_o         = '0;
        m_rvalid_o[fifo_head] = rsp_pop;
    end

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        rr_ptr_d  = handshake ? ~sel : rr_ptr_q;
        err_d     = err_q || (s_rvalid_i && fifo_empty);
        case (state_q)
            IDLE: begin
                if (s_req_o && !s_gnt_i) begin
                    state_d   = WAIT;
                    lock_id_d = winner;
                end
            end
            WAIT: begin
                if (!m_req_i[lock_id_q]) begin
                    state_d   = IDLE;
                    lock_id_d = 1'b0;
                    err_d     = 1'b1;
                end else if (s_gnt_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= 1'b0;
            lock_id_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
        end
    end

    arb_route_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_route_fifo (
        .clk     (clk),
        .arst_n  (arst_n),
        .push_i  (handshake),
        .data_i  (sel),
        .pop_i   (s_rvalid_i),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef MEM_PORT_ARB_PERF_EN
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (both_req && (m_gnt_o != 2'b11) && (conflict_cnt_q != 32'hFFFF_FFFF))
            conflict_cnt_d = conflict_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) conflict_cnt_q <= '0;
        else         conflict_cnt_q <= conflict_cnt_d;
    end

    assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one core-style memory port (req/gnt/rvalid protocol) between two requesters. Example pairing: instruction and data ports of a cv32e40p-class core contending for one memory, or two bus bridges.
- Round-robin arbitration with a request lock during a pending grant.
- An in-order routing FIFO steers each response back to the requester that issued it.
- Sits between the core memory interfaces and a single memory or AXI-bridge slave port inside a tile.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 2, routing FIFO depth (granted but not yet responded transactions); power of two, ≥1.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- m_req_i  in  2  request per requester (index 0, 1)
- m_gnt_o  out  2  grant per requester
- m_rvalid_o  out  2  response valid per requester
- m_we_i  in  2  write enable per requester
- m_addr_i  in  2×ADDR_WIDTH  packed address array
- m_be_i  in  2×DATA_WIDTH/8  packed byte enables
- m_wdata_i  in  2×DATA_WIDTH  packed write data
- m_rdata_o  out  2×DATA_WIDTH  read data (s_rdata_i broadcast to both)
- s_req_o  out  1  shared-port request
- s_gnt_i  in  1  shared-port grant
- s_rvalid_i  in  1  shared-port response valid
- s_we_o  out  1  / s_addr_o out ADDR_WIDTH / s_be_o out DATA_WIDTH/8 / s_wdata_o out DATA_WIDTH: muxed request fields
- s_rdata_i  in  DATA_WIDTH  response data
- err_o  out  1  sticky protocol error

Behaviour:
- Reset values: s_req_o=0, m_gnt_o=0, m_rvalid_o=0, err_o=0, rr_ptr=0, FIFO empty, state=IDLE.
- Request forwarding is combinational; grant and response paths are zero-latency. Registers: rr_ptr, lock_id, state, FIFO.
- Round robin:
  - rr_ptr names the highest-priority requester.
  - With both requesting, the winner is rr_ptr. With one requesting, that one wins.
  - On an accepted handshake (s_req_o && s_gnt_i), rr_ptr becomes ~winner.
- States:
  - IDLE: winner chosen combinationally. If s_req_o && !s_gnt_i, store lock_id=winner and go to WAIT.
  - WAIT: selection forced to lock_id regardless of the other requester. Shared-port fields stay stable, because requesters must hold req and fields until gnt. On s_gnt_i return to IDLE.
- Request forwarding:
  - s_req_o = m_req_i[sel] && !fifo_block.
  - m_gnt_o[sel] = s_gnt_i && s_req_o. The non-selected requester's grant is 0.
- Routing FIFO:
  - Push sel on an accepted handshake.
  - Pop on s_rvalid_i.
  - m_rvalid_o[head] = s_rvalid_i.
- Full FIFO: fifo_block = full && !s_rvalid_i. A push and pop in the same cycle when full is allowed, and the count is unchanged.
- Empty FIFO: a simultaneous push+pop with zero-latency response is not supported; a response needs a prior accepted request.
- Errors (err_o sticks until reset):
  - s_rvalid_i while the FIFO is empty: no m_rvalid_o asserted.
  - m_req_i[lock_id] dropping while in WAIT. In this case return to IDLE and clear the lock.
- Pointer wrap: FIFO pointers are log2(MAX_OUTSTANDING) wide and wrap naturally; count is log2+1 bits.
- Reset mid-operation: all state cleared immediately. Outstanding responses arriving after reset set err_o.

Optional Feature:
- Macro: MEM_PORT_ARB_PERF_EN.
- Enabled: adds output conflict_cnt_o (32 bits). It increments, saturating at 32'hFFFF_FFFF, in every cycle where both m_req_i bits are high and one requester is not granted. Reset value 0.
- Disabled: the port and the counter do not exist.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef arb_state_t {IDLE, WAIT}
  - localparam N_REQ=2
  - typedef for the requester index
- One natural sub-module: arb_route_fifo. It is a synchronous FIFO of requester indices with push/pop/full/empty and simultaneous push+pop support, reusable elsewhere in the tile.

Test Plan:
- Single requester, reads: m0 issues addr 0x100 and 0x104 with s_gnt_i=1 and s_rvalid_i one cycle later → m_gnt_o=2'b01 each cycle, m_rvalid_o=2'b01, m_rdata_o[0]=s_rdata_i, err_o=0.
- Contention: both request every cycle, s_gnt_i=1 → grants alternate 01,10,01,10 starting at m0 after reset; responses route in issue order.
- Stall lock: m1 alone requests addr 0x2000, s_gnt_i=0 for 3 cycles, m0 requests in cycle 2 → s_addr_o holds 0x2000, m_gnt_o[0]=0 until m1 is granted in cycle 4, then m0 wins next.
- FIFO full, MAX_OUTSTANDING=2: two accepted with no responses → third s_req_o=0. Assert s_rvalid_i → same-cycle grant of the third, and m_rvalid_o goes to the first issuer.
- Spurious response: s_rvalid_i=1 with the FIFO empty → m_rvalid_o=0, err_o=1 and it stays 1 until arst_n is pulsed low.
- With MEM_PORT_ARB_PERF_EN: 10 cycles of dual requests, s_gnt_i=1 → conflict_cnt_o=10. Without the macro the bench compiles with no such port.
